// File: rtl/pipeline_exe_muldiv.sv
// Iterative RV32M multiply/divide unit for the EXE stage.
// Performs a shift-add multiply or a restoring divide at one bit per cycle and holds the EXE stage while it runs.
module pipeline_exe_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start_e_i,
    input  logic [2:0]      muldiv_op_e_i,
    input  logic [XLEN-1:0] rs1_e_i,
    input  logic [XLEN-1:0] rs2_e_i,
    input  logic            trap_flush_t_i,
    output logic            busy_e_o,
    output logic            done_e_o,
    output logic [XLEN-1:0] result_e_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [63:0] acc_reg, acc_next;
    logic [31:0] opnd_reg, opnd_next;
    logic [2:0]  op_reg, op_next;
    logic        sa_reg, sa_next, sb_reg, sb_next;
    logic [31:0] result_reg, result_next;

    // Operand decode for the incoming instruction
    logic        a_neg, b_neg, div_zero, div_ovf;
    logic [31:0] abs_a, abs_b, special_res;

    always_comb begin
        a_neg    = rs1_e_i[31] & ((muldiv_op_e_i == 3'b001) | (muldiv_op_e_i == 3'b010) |
                                  (muldiv_op_e_i == 3'b100) | (muldiv_op_e_i == 3'b110));
        b_neg    = rs2_e_i[31] & ((muldiv_op_e_i == 3'b001) | (muldiv_op_e_i == 3'b100) |
                                  (muldiv_op_e_i == 3'b110));
        abs_a    = a_neg ? -rs1_e_i : rs1_e_i;
        abs_b    = b_neg ? -rs2_e_i : rs2_e_i;
        div_zero = (rs2_e_i == 32'd0);
        div_ovf  = !muldiv_op_e_i[0] && (rs1_e_i == 32'h8000_0000) && (rs2_e_i == 32'hFFFF_FFFF);
        if (div_zero)
            special_res = muldiv_op_e_i[1] ? rs1_e_i : 32'hFFFF_FFFF;
        else
            special_res = muldiv_op_e_i[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration: multiply keeps {hi, multiplier} and shifts right; divide keeps {rem, quotient} and shifts left
    logic [32:0] mul_sum, div_diff;
    logic [63:0] step_mul, step_div, step, prod;
    logic [31:0] quo, rem, final_res;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        step_mul = {mul_sum, acc_reg[31:1]};
        div_diff = acc_reg[63:31] - {1'b0, opnd_reg};
        step_div = div_diff[32] ? {acc_reg[62:0], 1'b0} : {div_diff[31:0], acc_reg[30:0], 1'b1};
        step     = op_reg[2] ? step_div : step_mul;

        prod = (sa_reg ^ sb_reg) ? -step : step;
        quo  = (sa_reg ^ sb_reg) ? -step[31:0] : step[31:0];
        rem  = sa_reg ? -step[63:32] : step[63:32];
        case (op_reg)
            3'b000:                 final_res = prod[31:0];
            3'b001, 3'b010, 3'b011: final_res = prod[63:32];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        op_next     = op_reg;
        sa_next     = sa_reg;
        sb_next     = sb_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (start_e_i) begin
                    op_next = muldiv_op_e_i;
                    sa_next = a_neg;
                    sb_next = b_neg;
                    if (muldiv_op_e_i[2] && (div_zero || div_ovf)) begin
                        result_next = special_res;
                        state_next  = DONE;
                    end else begin
                        cnt_next   = 6'd32;
                        opnd_next  = muldiv_op_e_i[2] ? abs_b : abs_a;
                        acc_next   = {32'd0, muldiv_op_e_i[2] ? abs_a : abs_b};
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                acc_next = step;
                cnt_next = cnt_reg - 6'd1;
                if (cnt_reg == 6'd1) begin
                    result_next = final_res;
                    state_next  = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush kills the instruction outright, including a completion in this very cycle
        if (trap_flush_t_i) begin
            state_next  = IDLE;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            cnt_reg    <= 6'd0;
            acc_reg    <= 64'd0;
            opnd_reg   <= 32'd0;
            op_reg     <= 3'd0;
            sa_reg     <= 1'b0;
            sb_reg     <= 1'b0;
            result_reg <= 32'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            op_reg     <= op_next;
            sa_reg     <= sa_next;
            sb_reg     <= sb_next;
            result_reg <= result_next;
        end
    end

    assign busy_e_o   = ((state_reg == IDLE) && start_e_i) || (state_reg == CALC);
    assign done_e_o   = (state_reg == DONE) && !trap_flush_t_i;
    assign result_e_o = result_reg;

endmodule

// File: tb/tb_pipeline_exe_muldiv.sv
// Self-checking bench for pipeline_exe_muldiv: directed plan vectors plus random ops against a 64-bit arithmetic model.
`timescale 1ns/1ps
module tb_pipeline_exe_muldiv;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;
    int done_total = 0;

    always #5 clk = ~clk;

    pipeline_exe_muldiv #(.XLEN(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start_e_i      (start),
        .muldiv_op_e_i  (op),
        .rs1_e_i        (a),
        .rs2_e_i        (b),
        .trap_flush_t_i (flush),
        .busy_e_o       (busy),
        .done_e_o       (done),
        .result_e_o     (result)
    );

    always @(negedge clk) if (done) done_total++;

    // Architectural RV32M result computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        p  = 64'd0;
        case (o)
            3'd0: p = ux * uy;
            3'd1: p = sx * sy;
            3'd2: p = sx * uy;
            3'd3: p = ux * uy;
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sx / sy);
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
            3'd6: return (y == 0) ? x : (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'd0 : 32'(sx % sy);
            default: return (y == 0) ? x : 32'(ux % uy);
        endcase
        return (o == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit ref_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    // Entered just after a rising edge; returns just after the edge that ends the DONE cycle with start low
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int nb, output int dc);
        start = 1'b1; op = o; a = x; b = y;
        nb = 0; dc = -1; res = 32'd0;
        for (int c = 0; c < 60 && dc < 0; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin dc = c; res = result; end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, result} !== 34'd0) begin
            n_err++; $display("FAIL reset_state: busy=%0b done=%0b result=%h required 0 0 00000000", busy, done, result);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_timing();
        logic [31:0] r; int nb, dc;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, r, nb, dc);
        n_vec++;
        if (r !== 32'hFFFF_FFEB || nb != 33 || dc != 33) begin
            n_err++; $display("FAIL mul_timing: result=%h busy=%0d done_at=%0d required ffffffeb 33 33", r, nb, dc);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL mul_done_pulse: done=%0b busy=%0b required 0 0", done, busy);
        end
        $display("mul 7*fffffffd -> %h busy=%0d done_at=%0d", r, nb, dc);
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  tops[11] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] ta[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] texp[11] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                  32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] r; int nb, dc, et;
        for (int i = 0; i < 11; i++) begin
            et = ref_special(tops[i], ta[i], tb[i]) ? 1 : 33;
            do_op(tops[i], ta[i], tb[i], r, nb, dc);
            n_vec++;
            if (r !== texp[i] || nb != et || dc != et) begin
                n_err++;
                $display("FAIL directed_%0d: op=%0d a=%h b=%h result=%h busy=%0d done_at=%0d required %h %0d %0d",
                         i, tops[i], ta[i], tb[i], r, nb, dc, texp[i], et, et);
            end
            $display("directed op=%0d a=%h b=%h -> %h busy=%0d done_at=%0d", tops[i], ta[i], tb[i], r, nb, dc);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; int nb, dc, nd;
        do_op(3'd0, 32'd5, 32'd6, r, nb, dc);
        start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL flush_cycle_done: done=%0b required 0", done);
        end
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || result !== 32'd30) begin
            n_err++; $display("FAIL flush_idle: busy=%0b result=%h required 0 0000001e", busy, result);
        end
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_vec++;
        if (nd != 0 || result !== 32'd30) begin
            n_err++; $display("FAIL flush_no_done: done_pulses=%0d result=%h required 0 0000001e", nd, result);
        end
        @(posedge clk); #1;
        do_op(3'd0, 32'd3, 32'd4, r, nb, dc);
        n_vec++;
        if (r !== 32'd12 || nb != 33 || dc != 33) begin
            n_err++; $display("FAIL flush_recover: result=%h busy=%0d done_at=%0d required 0000000c 33 33", r, nb, dc);
        end
        $display("flush then mul 3*4 -> %h", r);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 3'd5; a = $urandom; b = $urandom_range(1, 1000);
        repeat (8) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        n_vec++;
        if (done !== 1'b0 || result !== 32'd0) begin
            n_err++; $display("FAIL reset_async: done=%0b result=%h required 0 00000000", done, result);
        end
        start = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: busy=%0b required 0", busy);
        end
        @(negedge clk);
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_err++; $display("FAIL reset_release: busy=%0b done=%0b result=%h required 0 0 00000000", busy, done, result);
        end
        $display("async reset mid-calc checked");
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, x, y; int nb, dc, d0;
        d0 = done_total;
        for (int i = 0; i < 4; i++) begin
            x = $urandom; y = $urandom_range(1, 32'hFFFF);
            do_op(3'd5, x, y, r, nb, dc);
            n_vec++;
            if (r !== ref_result(3'd5, x, y) || nb != 33 || dc != 33) begin
                n_err++; $display("FAIL b2b_%0d: result=%h busy=%0d done_at=%0d required %h 33 33",
                                  i, r, nb, dc, ref_result(3'd5, x, y));
            end
            $display("b2b divu %h/%h -> %h", x, y, r);
        end
        n_vec++;
        if (done_total - d0 != 4) begin
            n_err++; $display("FAIL b2b_count: done_pulses=%0d required 4", done_total - d0);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, x, y, e; logic [2:0] o; int nb, dc, et;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 9))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = $urandom_range(0, 255); y = $urandom_range(0, 15); end
                default: ;
            endcase
            e  = ref_result(o, x, y);
            et = ref_special(o, x, y) ? 1 : 33;
            do_op(o, x, y, r, nb, dc);
            n_vec++;
            if (r !== e || nb != et || dc != et) begin
                n_err++; $display("FAIL random_%0d: op=%0d a=%h b=%h result=%h busy=%0d done_at=%0d required %h %0d %0d",
                                  i, o, x, y, r, nb, dc, e, et, et);
            end
            $display("random op=%0d a=%h b=%h -> %h", o, x, y, r);
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_directed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
